// File: rtl/jtag_pkg.sv
// Shared JTAG output-stage definitions: FSM encoding, delay limit, SEL width helper.
package jtag_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FLUSH = 2'd2
  } tdo_state_e;

  localparam int unsigned TDO_MAX_DELAY = 7;

  // Width of a chain index; a single chain still gets a 1-bit select.
  function automatic int unsigned sel_width(input int unsigned channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/tdo_delay_line.sv
// Retiming shift register for {valid,data} behind the TDO capture stage.
// Also reports the last-stage valid and the "any stage valid" condition as they
// will be after the coming edge, so the controller can decide without waiting.
module tdo_delay_line
  import jtag_pkg::*;
#(
  parameter int unsigned DELAY = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,       // capture stage valid, current
  input  logic in_data,        // capture stage data, current
  input  logic in_valid_next,  // capture stage valid after the coming edge
  output logic out_valid,
  output logic out_data,
  output logic out_valid_next,
  output logic any_valid_next
);

  localparam int unsigned DEPTH = (DELAY > TDO_MAX_DELAY) ? TDO_MAX_DELAY : DELAY;

  if (DEPTH == 0) begin : g_pass
    assign out_valid      = in_valid;
    assign out_data       = in_data;
    assign out_valid_next = in_valid_next;
    assign any_valid_next = in_valid_next;
  end else begin : g_pipe
    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] d_q;
    logic [DEPTH-1:0] v_shift;
    logic [DEPTH-1:0] d_shift;

    // Next contents of the retiming stages: everything moves up one place.
    always_comb begin
      v_shift    = v_q << 1;
      d_shift    = d_q << 1;
      v_shift[0] = in_valid;
      d_shift[0] = in_data;
    end

    // Unconditional shift every edge; synchronous clear.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= '0;
        d_q <= '0;
      end else begin
        v_q <= v_shift;
        d_q <= d_shift;
      end
    end

    assign out_valid      = v_q[DEPTH-1];
    assign out_data       = d_q[DEPTH-1];
    assign out_valid_next = v_shift[DEPTH-1];
    assign any_valid_next = in_valid_next | (|v_shift);
  end

endmodule

// File: rtl/tdo_out_stage.sv
// TDO output stage: selects one scan chain, captures it on TCKN, retimes it by
// DELAY extra stages, and tracks bursts (bit count, done pulse, bad-select flag).
module tdo_out_stage
  import jtag_pkg::*;
#(
  parameter  int unsigned CHANNELS = 2,
  parameter  int unsigned DELAY    = 0,
  parameter  int unsigned CNT_W    = 16,
  localparam int unsigned SEL_W    = sel_width(CHANNELS)
) (
  input  logic                TCKN,
  input  logic                RST,
  input  logic                SHIFT,
  input  logic [SEL_W-1:0]    SEL,
  input  logic [CHANNELS-1:0] CHAIN_TDO,
  output logic                TDO,
  output logic                TDO_EN,
  output logic [CNT_W-1:0]    BIT_CNT,
  output logic                DONE,
  output logic                SEL_ERR
);

  localparam int unsigned PAD_W = 1 << SEL_W;

  logic [PAD_W-1:0] chain_pad;
  logic             sel_bad;
  logic             d_sel;

  logic             s0_v;
  logic             s0_d;
  logic             last_v_next;
  logic             any_v_next;

  tdo_state_e       state;
  tdo_state_e       state_n;
  logic             done_n;
  logic             start;
  logic [CNT_W-1:0] cnt_n;
  logic             err_n;

  // Chain select; unpopulated indices read as 0 through the zero-padded vector.
  always_comb begin
    chain_pad                 = '0;
    chain_pad[CHANNELS-1:0]   = CHAIN_TDO;
    sel_bad                   = (CHANNELS > 1) && (32'(SEL) >= CHANNELS);
    d_sel                     = (CHANNELS == 1) ? CHAIN_TDO[0] : chain_pad[SEL];
  end

  // Capture stage: takes a new bit while shifting, otherwise drops valid and keeps data.
  always_ff @(posedge TCKN) begin
    if (RST) begin
      s0_v <= 1'b0;
      s0_d <= 1'b0;
    end else if (SHIFT) begin
      s0_v <= 1'b1;
      s0_d <= d_sel;
    end else begin
      s0_v <= 1'b0;
    end
  end

  tdo_delay_line #(
    .DELAY (DELAY)
  ) u_delay (
    .clk            (TCKN),
    .rst            (RST),
    .in_valid       (s0_v),
    .in_data        (s0_d),
    .in_valid_next  (SHIFT),
    .out_valid      (TDO_EN),
    .out_data       (TDO),
    .out_valid_next (last_v_next),
    .any_valid_next (any_v_next)
  );

  // Burst controller next state; decisions use pipeline valids as they will be after the edge.
  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    start   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (SHIFT) begin
          state_n = ST_SHIFT;
          start   = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (!SHIFT) begin
          if (any_v_next) begin
            state_n = ST_FLUSH;
          end else begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        if (SHIFT) begin
          state_n = ST_SHIFT;
        end else if (!any_v_next) begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Burst statistics: a new burst clears the count and flag before this edge's update applies.
  always_comb begin
    cnt_n = start ? '0 : BIT_CNT;
    if (last_v_next && (cnt_n != '1)) begin
      cnt_n = cnt_n + CNT_W'(1);
    end
    err_n = (start ? 1'b0 : SEL_ERR) | (SHIFT & sel_bad);
  end

  // Controller and statistics registers.
  always_ff @(posedge TCKN) begin
    if (RST) begin
      state   <= ST_IDLE;
      DONE    <= 1'b0;
      BIT_CNT <= '0;
      SEL_ERR <= 1'b0;
    end else begin
      state   <= state_n;
      DONE    <= done_n;
      BIT_CNT <= cnt_n;
      SEL_ERR <= err_n;
    end
  end

endmodule

// File: tb/tb_tdo_out_stage.sv
// Scoreboard bench for tdo_out_stage across three parameter sets.
// The reference model works from the per-edge history of SHIFT and the selected bit.
module tb_tdo_out_stage;

  localparam int NCFG = 3;
  localparam int CFG_CH [NCFG] = '{2, 3, 1};
  localparam int CFG_DL [NCFG] = '{0, 3, 2};
  localparam int CFG_CW [NCFG] = '{16, 3, 4};

  typedef struct {
    bit          tdo;
    bit          en;
    bit          done;
    bit          err;
    int unsigned cnt;
  } exp_t;

  logic tckn;
  int   n_vec  = 0;
  int   n_bad  = 0;
  int   n_done = 0;

  initial tckn = 1'b0;
  always #5 tckn = ~tckn;

  for (genvar g = 0; g < NCFG; g++) begin : cfg
    localparam int CH = CFG_CH[g];
    localparam int DL = CFG_DL[g];
    localparam int CW = CFG_CW[g];
    localparam int SW = (CH > 1) ? $clog2(CH) : 1;
    localparam int unsigned CMAX = (32'd1 << CW) - 32'd1;

    logic          rst;
    logic          shift;
    logic [SW-1:0] sel;
    logic [CH-1:0] chain;
    logic          tdo;
    logic          tdo_en;
    logic [CW-1:0] bit_cnt;
    logic          done;
    logic          sel_err;

    tdo_out_stage #(
      .CHANNELS (CH),
      .DELAY    (DL),
      .CNT_W    (CW)
    ) dut (
      .TCKN      (tckn),
      .RST       (rst),
      .SHIFT     (shift),
      .SEL       (sel),
      .CHAIN_TDO (chain),
      .TDO       (tdo),
      .TDO_EN    (tdo_en),
      .BIT_CNT   (bit_cnt),
      .DONE      (done),
      .SEL_ERR   (sel_err)
    );

    exp_t        q[$];
    bit          hs[$];
    bit          hd[$];
    bit          in_burst;
    int unsigned cnt;
    bit          err;

    task automatic predict(input bit r, input bit s, input logic [SW-1:0] sl,
                           input logic [CH-1:0] c);
      exp_t e;
      int   n;
      bit   bad;
      bit   dbit;
      bit   quiet;
      e = '{default: 0};
      if (r) begin
        hs.delete();
        hd.delete();
        in_burst = 1'b0;
        cnt      = 0;
        err      = 1'b0;
        q.push_back(e);
        return;
      end
      bad  = (CH > 1) && (int'(sl) >= CH);
      dbit = 1'b0;
      if (CH == 1) dbit = c[0];
      else for (int i = 0; i < CH; i++) if (i == int'(sl)) dbit = c[i];
      hs.push_back(s);
      hd.push_back(dbit);
      n = hs.size() - 1;
      if (s && !in_burst) begin
        in_burst = 1'b1;
        cnt      = 0;
        err      = 1'b0;
      end
      if (s && bad) err = 1'b1;
      if (n >= DL) e.en = hs[n-DL];
      for (int k = n - DL; k >= 0; k--) begin
        if (hs[k]) begin
          e.tdo = hd[k];
          break;
        end
      end
      if (e.en && cnt < CMAX) cnt++;
      quiet = (n >= DL + 1) && hs[n-DL-1];
      for (int k = n - DL; k <= n; k++) if (hs[k]) quiet = 1'b0;
      if (quiet) begin
        e.done   = 1'b1;
        in_burst = 1'b0;
      end
      e.cnt = cnt;
      e.err = err;
      q.push_back(e);
    endtask

    task automatic step(input bit r, input bit s, input logic [SW-1:0] sl,
                        input logic [CH-1:0] c);
      rst   = r;
      shift = s;
      sel   = sl;
      chain = c;
      predict(r, s, sl, c);
      @(posedge tckn);
      #2;
    endtask

    task automatic burst_bit(input bit b, input logic [SW-1:0] sl);
      logic [CH-1:0] c;
      c = CH'($urandom);
      for (int i = 0; i < CH; i++) if (i == int'(sl)) c[i] = b;
      if (CH == 1) c[0] = b;
      step(1'b0, 1'b1, sl, c);
    endtask

    task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, SW'($urandom), CH'($urandom));
    endtask

    // Stimulus: directed bursts, then randomised SHIFT runs with occasional reset.
    initial begin
      logic [SW-1:0] hi;
      logic [SW-1:0] sel_a;
      bit            pat [4];
      bit            cur;
      bit            r;
      pat      = '{1'b1, 1'b0, 1'b1, 1'b1};
      hi       = '1;
      sel_a    = SW'(CH - 1);
      in_burst = 1'b0;
      cnt      = 0;
      err      = 1'b0;
      cur      = 1'b0;
      step(1'b1, 1'b0, '0, '0);
      step(1'b1, 1'b1, '0, '1);
      idle(1);
      for (int i = 0; i < 4; i++) burst_bit(pat[i], sel_a);
      idle(DL + 3);
      for (int i = 0; i < 3; i++) burst_bit(1'($urandom), SW'(i % CH));
      idle(1);
      for (int i = 0; i < 3; i++) burst_bit(1'($urandom), SW'(i % CH));
      idle(DL + 3);
      burst_bit(1'b1, '0);
      burst_bit(1'b1, hi);
      burst_bit(1'b1, '0);
      burst_bit(1'b0, '0);
      idle(DL + 3);
      burst_bit(1'b1, '0);
      burst_bit(1'b1, '0);
      idle(DL + 3);
      for (int i = 0; i < 10; i++) burst_bit(1'($urandom), SW'($urandom));
      idle(DL + 3);
      for (int i = 0; i < 3; i++) burst_bit(1'b1, sel_a);
      step(1'b0, 1'b0, '0, '0);
      step(1'b1, 1'b0, '0, '0);
      idle(DL + 3);
      for (int i = 0; i < 500; i++) begin
        r = ($urandom_range(0, 63) == 0);
        if ($urandom_range(0, 3) == 0) cur = !cur;
        step(r, cur, SW'($urandom), CH'($urandom));
      end
      idle(DL + 3);
      @(posedge tckn);
      #2;
      if (q.size() != 0) begin
        n_bad++;
        $display("FAIL cfg%0d queue_drain got %0d pending required 0", g, q.size());
      end
      n_done++;
    end

    // Monitor: one expected entry per edge, compared just after the edge.
    initial begin
      exp_t e;
      forever begin
        @(posedge tckn);
        #1;
        if (q.size() > 0) begin
          e = q.pop_front();
          n_vec++;
          if (tdo !== e.tdo) begin
            n_bad++;
            $display("FAIL cfg%0d TDO t=%0t got %b required %b", g, $time, tdo, e.tdo);
          end
          if (tdo_en !== e.en) begin
            n_bad++;
            $display("FAIL cfg%0d TDO_EN t=%0t got %b required %b", g, $time, tdo_en, e.en);
          end
          if (done !== e.done) begin
            n_bad++;
            $display("FAIL cfg%0d DONE t=%0t got %b required %b", g, $time, done, e.done);
          end
          if (sel_err !== e.err) begin
            n_bad++;
            $display("FAIL cfg%0d SEL_ERR t=%0t got %b required %b", g, $time, sel_err, e.err);
          end
          if (32'(bit_cnt) !== e.cnt) begin
            n_bad++;
            $display("FAIL cfg%0d BIT_CNT t=%0t got %0d required %0d", g, $time, bit_cnt, e.cnt);
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 20000; i++) begin
      if (n_done == NCFG) break;
      @(posedge tckn);
    end
    if (n_done != NCFG) begin
      n_bad++;
      $display("FAIL timeout got %0d configs finished required %0d", n_done, NCFG);
    end
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
